// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and key-size decode for the round-key sequencer.
package aes_pkg;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  localparam logic [2:0] KEYSIZE_192 = 3'b010;
  localparam logic [2:0] KEYSIZE_256 = 3'b100;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

  // Unrecognised encodings fall back to AES-128.
  function automatic logic [3:0] nr_from_keysize(input logic [2:0] key_size);
    case (key_size)
      KEYSIZE_192: nr_from_keysize = NR_192;
      KEYSIZE_256: nr_from_keysize = NR_256;
      default:     nr_from_keysize = NR_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_rk_select.sv
// Combinational round-key selector: picks the 128-bit slice idx out of the flat key snapshot.
module aes_rk_select
  import aes_pkg::*;
#(
  parameter int KEY_W = 1920,
  parameter int BLK_W = 128
) (
  input  logic [KEY_W-1:0] snapshot,
  input  logic [3:0]       idx,
  output logic [BLK_W-1:0] key
);

  localparam int NKEYS = KEY_W / BLK_W;

  // Slots past the last stored key read as zero so every 4-bit index is defined.
  logic [BLK_W-1:0] keys [16];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_slot
      if (gi < NKEYS) begin : g_key
        assign keys[gi] = snapshot[gi*BLK_W +: BLK_W];
      end else begin : g_zero
        assign keys[gi] = '0;
      end
    end
  endgenerate

  assign key = keys[idx];

endmodule

// File: rtl/aes_round_key_sequencer.sv
// Streams AES round keys from a start-time snapshot of the expanded key over valid/ready.
// Optional AES_INV_KEY_ORDER_EN adds an `inverse` input that reverses the key order for decryption.
module aes_round_key_sequencer
  import aes_pkg::*;
#(
  parameter int KEY_W  = 1920,
  parameter int BLK_W  = 128,
  parameter int NR_MAX = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       keySize,
  input  logic [KEY_W-1:0] keyExp,
`ifdef AES_INV_KEY_ORDER_EN
  input  logic             inverse,
`endif
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [BLK_W-1:0] rk_data,
  output logic [3:0]       rk_index,
  output logic             rk_last,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] IDX_MAX = NR_MAX[3:0];

  state_t           state_reg, state_next;
  logic [KEY_W-1:0] snap_reg;
  logic [3:0]       nr_reg;
  logic [3:0]       idx_reg, idx_next;
  logic [3:0]       nr_dec, first_idx, final_idx;
  logic             load_key;
  logic             inv_mode;
  logic [BLK_W-1:0] sel_key;
  logic [BLK_W-1:0] rk_data_reg;
  logic [3:0]       rk_index_reg;
  logic             rk_last_reg, rk_valid_reg, done_reg;

`ifdef AES_INV_KEY_ORDER_EN
  logic inv_mode_reg;
  assign inv_mode = inv_mode_reg;
`else
  assign inv_mode = 1'b0;
`endif

  assign nr_dec    = (nr_from_keysize(keySize) > IDX_MAX) ? IDX_MAX : nr_from_keysize(keySize);
  assign first_idx = inv_mode ? nr_reg : 4'd0;
  assign final_idx = inv_mode ? 4'd0 : nr_reg;

  // The mux looks at idx_next so the selected key lands in rk_data_reg on the same edge idx moves.
  aes_rk_select #(
    .KEY_W(KEY_W),
    .BLK_W(BLK_W)
  ) u_rk_select (
    .snapshot(snap_reg),
    .idx     (idx_next),
    .key     (sel_key)
  );

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    load_key   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        idx_next   = first_idx;
        load_key   = 1'b1;
        state_next = STREAM;
      end
      STREAM: begin
        if (rk_valid_reg && rk_ready) begin
          if (rk_last_reg) begin
            state_next = DONE;
          end else begin
            idx_next = inv_mode ? (idx_reg - 4'd1) : (idx_reg + 4'd1);
            load_key = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      snap_reg     <= '0;
      nr_reg       <= '0;
      idx_reg      <= '0;
      rk_data_reg  <= '0;
      rk_index_reg <= '0;
      rk_last_reg  <= 1'b0;
      rk_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
`ifdef AES_INV_KEY_ORDER_EN
      inv_mode_reg <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      rk_valid_reg <= (state_next == STREAM);
      done_reg     <= (state_next == DONE);
      if (state_reg == IDLE && start) begin
        snap_reg <= keyExp;
        nr_reg   <= nr_dec;
`ifdef AES_INV_KEY_ORDER_EN
        inv_mode_reg <= inverse;
`endif
      end
      if (load_key) begin
        rk_data_reg  <= sel_key;
        rk_index_reg <= idx_next;
        rk_last_reg  <= (idx_next == final_idx);
      end
    end
  end

  assign rk_valid = rk_valid_reg;
  assign rk_data  = rk_data_reg;
  assign rk_index = rk_index_reg;
  assign rk_last  = rk_last_reg;
  assign done     = done_reg;
  assign busy     = (state_reg == LOAD) || (state_reg == STREAM);

endmodule
